logic_unit_arbiter: RTL and testbench

Shares one inv_uinit_logic instance (NUM_REQ requesters, one logic datapath) using round-robin arbitration and valid/ready handshakes. Each requester supplies an opcode and two operands. The block decodes the opcode into c_and/c_or/c_xor/c_inv, drives the shared unit and registers the result in a single output stage with backpressure. It sits between the instruction-issue front ends and the ALU result bus.

---
 rtl/logic_alu_pkg.sv | 12 +
 rtl/inv_uinit_logic.sv | 24 ++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/logic_unit_arbiter.sv | 118 +++++++++++
 tb/tb_logic_unit_arbiter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/logic_alu_pkg.sv
// Shared opcode encodings for the logic ALU slice.
// Imported by the arbiter top and its datapath.
package logic_alu_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_BAD = 2'b11;

  localparam int INV_BIT = 2;

endpackage

// File: rtl/inv_uinit_logic.sv
// Bitwise logic datapath: AND/OR/XOR with optional inversion.
// With no select active the result is all-zero (or all-one if inverted).
module inv_uinit_logic #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_and,
  input  logic             c_or,
  input  logic             c_xor,
  input  logic             c_inv,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] r;

  always_comb begin
    r = ({WIDTH{c_and}} & (a & b))
      | ({WIDTH{c_or}}  & (a | b))
      | ({WIDTH{c_xor}} & (a ^ b));
    y = c_inv ? ~r : r;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a rotating start pointer.
// Grants at most one requester per cycle while enable is high.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             enable,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] ptr;
  logic             found;

  always_comb begin
    int j;
    j       = 0;
    found   = 1'b0;
    gnt     = '0;
    gnt_idx = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[IDX_W'(j)]) begin
        found   = 1'b1;
        gnt_idx = IDX_W'(j);
      end
    end
    if (enable && found) gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (enable && found) begin
      ptr <= (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Shares one logic datapath among NUM_REQ requesters with
// round-robin grant and a single registered response stage.
module logic_unit_arbiter
  import logic_alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [3*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_a,
  input  logic [WIDTH*NUM_REQ-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     rsp_err,
  output logic [CNT_W-1:0]         op_count
);

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               stage_free;
  logic               enable;
  logic               accept;
  logic [2:0]         sel_op;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic [WIDTH-1:0]   y;
  logic               c_and;
  logic               c_or;
  logic               c_xor;
  logic               c_inv;
  logic               bad;

  // rst_n gate keeps req_ready low while reset is asserted
  assign stage_free = !rsp_valid || rsp_ready;
  assign enable     = rst_n && stage_free;
  assign accept     = |gnt;
  assign req_ready  = gnt;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .enable  (enable),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_op = sel_op | req_op[3*i +: 3];
        sel_a  = sel_a  | req_a[WIDTH*i +: WIDTH];
        sel_b  = sel_b  | req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  always_comb begin
    c_and = 1'b0;
    c_or  = 1'b0;
    c_xor = 1'b0;
    bad   = 1'b0;
    c_inv = sel_op[INV_BIT];
    unique case (1'b1)
      (sel_op[1:0] == OP_AND): c_and = 1'b1;
      (sel_op[1:0] == OP_OR):  c_or  = 1'b1;
      (sel_op[1:0] == OP_XOR): c_xor = 1'b1;
      (sel_op[1:0] == OP_BAD): bad   = 1'b1;
    endcase
  end

  inv_uinit_logic #(
    .WIDTH (WIDTH)
  ) u_logic (
    .a     (sel_a),
    .b     (sel_b),
    .c_and (c_and),
    .c_or  (c_or),
    .c_xor (c_xor),
    .c_inv (c_inv),
    .y     (y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_err   <= 1'b0;
      op_count  <= '0;
    end else begin
      if (accept) begin
        rsp_valid <= 1'b1;
        rsp_data  <= y;
        rsp_id    <= gnt_idx;
        rsp_err   <= bad;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      if (rsp_valid && rsp_ready) op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter with a response scoreboard.
// Expected responses are queued at issue and checked by a monitor.
module tb_logic_unit_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [2:0] op0, op1;
  logic [7:0] a0, a1, b0, b1;
  logic [5:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [0:0] rsp_id;
  logic       rsp_err;
  logic [3:0] op_count;

  typedef struct {
    logic [7:0] d;
    logic       id;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk;
  int   n_fail;

  assign req_op = {op1, op0};
  assign req_a  = {a1, a0};
  assign req_b  = {b1, b0};

  logic_unit_arbiter #(
    .WIDTH   (8),
    .NUM_REQ (2),
    .ID_W    (1),
    .CNT_W   (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic id,
                      input logic err);
    exp_t e;
    e.d = d;
    e.id = id;
    e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a response is consumed when valid&&ready before the edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_rsp: got %0h expected none", rsp_data);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_data", 32'(rsp_data), 32'(e.d));
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 2'b00;
    op0 = '0; op1 = '0;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0;

    repeat (2) step();
    req_valid = 2'b11;
    @(negedge clk);
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_count", 32'(op_count), 0);
    chk("rst_ready", 32'(req_ready), 0);
    step();
    rst_n = 1'b1;
    req_valid = 2'b00;

    // single NAND from requester 0
    step();
    req_valid = 2'b01; op0 = 3'b100; a0 = 8'hF0; b0 = 8'h3C;
    push(8'hCF, 1'b0, 1'b0);
    @(negedge clk);
    chk("single_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 2'b00;
    @(negedge clk);
    chk("single_valid", 32'(rsp_valid), 1);

    // illegal opcodes from requester 1
    step();
    req_valid = 2'b10; op1 = 3'b111; a1 = 8'h5A; b1 = 8'hC3;
    push(8'hFF, 1'b1, 1'b1);
    @(negedge clk);
    chk("bad_ready0", 32'(req_ready), 32'h2);
    step();
    op1 = 3'b011;
    push(8'h00, 1'b1, 1'b1);
    @(negedge clk);
    chk("bad_ready1", 32'(req_ready), 32'h2);
    step();
    req_valid = 2'b00;

    // round robin, both requesters streaming
    req_valid = 2'b11;
    op0 = 3'b010; a0 = 8'hAA; b0 = 8'h0F;
    op1 = 3'b001; a1 = 8'hAA; b1 = 8'h0F;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) push(8'hA5, 1'b0, 1'b0);
      else push(8'hAF, 1'b1, 1'b0);
      @(negedge clk);
      chk("rr_ready", 32'(req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
      if (i > 0) chk("rr_nobubble", 32'(rsp_valid), 1);
      step();
    end
    req_valid = 2'b00;

    // backpressure
    req_valid = 2'b01; op0 = 3'b000; a0 = 8'hF0; b0 = 8'h3C;
    push(8'h30, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_ready0", 32'(req_ready), 32'h1);
    step();
    rsp_ready = 1'b0;
    req_valid = 2'b10; op1 = 3'b001; a1 = 8'h01; b1 = 8'h02;
    push(8'h03, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ready", 32'(req_ready), 0);
      chk("bp_data", 32'(rsp_data), 32'h30);
      chk("bp_id", 32'(rsp_id), 0);
      chk("bp_count", 32'(op_count), 7);
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_refill", 32'(req_ready), 32'h2);
    step();
    req_valid = 2'b00;
    @(negedge clk);
    chk("bp_valid", 32'(rsp_valid), 1);
    step();
    @(negedge clk);
    chk("drain_valid", 32'(rsp_valid), 0);
    chk("drain_hold", 32'(rsp_data), 32'h03);
    chk("drain_count", 32'(op_count), 9);

    // eight more ops wrap the 4-bit counter: 17 -> 1
    for (int i = 0; i < 8; i++) begin
      req_valid = 2'b01; op0 = 3'b010;
      a0 = 8'(i + 1); b0 = 8'h00;
      push(8'(i + 1), 1'b0, 1'b0);
      step();
    end
    req_valid = 2'b00;
    step();
    @(negedge clk);
    chk("wrap_count", 32'(op_count), 1);

    // reset with a stalled response pending
    step();
    rsp_ready = 1'b0;
    req_valid = 2'b01; op0 = 3'b010; a0 = 8'h33; b0 = 8'h00;
    step();
    req_valid = 2'b11;
    @(negedge clk);
    chk("pre_rst_valid", 32'(rsp_valid), 1);
    chk("pre_rst_ready", 32'(req_ready), 0);
    step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(rsp_valid), 0);
    chk("mid_rst_count", 32'(op_count), 0);
    chk("mid_rst_ready", 32'(req_ready), 0);
    step();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    op0 = 3'b000; a0 = 8'hFF; b0 = 8'h81;
    push(8'h81, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_rst_grant", 32'(req_ready), 32'h1);
    step();
    req_valid = 2'b00;
    repeat (3) step();
    @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 0);
    chk("final_count", 32'(op_count), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
